lut_table_writer: RTL and testbench

//   Runtime loader for the writable neuron truth tables of a LogicNets layer. Accepts a packed

---
 rtl/lut_table_writer_if.sv | 28 ++
 rtl/lut_table_writer.sv | 112 +++++++++++
 tb/tb_lut_table_writer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/lut_table_writer_if.sv
// Stream-in / LUT-RAM-write-out bundle for lut_table_writer.
// master = stream source and RAM-side observer, slave = the writer itself.
interface lut_table_writer_if #(
  parameter int unsigned FAN_IN    = 6,
  parameter int unsigned N_NEURONS = 64,
  parameter int unsigned WORD_W    = 8
);
  localparam int unsigned NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic              wr_en;
  logic [NW-1:0]     wr_neuron;
  logic [FAN_IN-1:0] wr_addr;
  logic              wr_data;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, wr_en, wr_neuron, wr_addr, wr_data
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, wr_en, wr_neuron, wr_addr, wr_data
  );
endinterface

// File: rtl/lut_table_writer.sv
// Unpacks a word stream of truth-table bits into a bit-serial write port feeding the per-neuron
// 2^FAN_IN x 1 LUT RAMs of a LogicNets layer.
module lut_table_writer #(
  parameter int unsigned FAN_IN    = 6,
  parameter int unsigned N_NEURONS = 64,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  lut_table_writer_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam int unsigned ENTRIES = 2 ** FAN_IN;
  localparam int unsigned TOTAL   = N_NEURONS * ENTRIES / WORD_W;
  localparam int unsigned NW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int unsigned IW      = FAN_IN + NW;
  localparam int unsigned WCW     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned RW      = $clog2(WORD_W + 1);

  if ((ENTRIES % WORD_W) != 0) begin : g_bad_word_w
    $error("WORD_W must divide 2**FAN_IN");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [RW-1:0]     rem;       // bits still queued behind the one currently on the write port
  logic [IW-1:0]     idx;       // flat {neuron, entry} index of the next write
  logic [WCW-1:0]    word_cnt;
  logic              accept;
  logic              final_word;

  assign bus.s_ready = (state == StLoad) && (rem == '0);
  assign accept      = bus.s_valid && bus.s_ready;
  assign final_word  = (word_cnt == WCW'(TOTAL - 1));
  assign busy        = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      sreg          <= '0;
      rem           <= '0;
      idx           <= '0;
      word_cnt      <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_neuron <= '0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          bus.wr_en <= 1'b0;
          if (start && !abort) begin
            state    <= StLoad;
            idx      <= '0;
            word_cnt <= '0;
            rem      <= '0;
            error    <= 1'b0;
          end
        end
        default: begin
          if (abort) begin
            state     <= StIdle;
            bus.wr_en <= 1'b0;
            rem       <= '0;
            sreg      <= '0;
            error     <= 1'b1;
          end else if (accept) begin
            if (bus.s_last != final_word) begin
              // Framing error: drop the word; nothing else is pending since s_ready implies rem == 0
              bus.wr_en <= 1'b0;
              error     <= 1'b1;
              state     <= StIdle;
            end else begin
              bus.wr_en     <= 1'b1;
              bus.wr_neuron <= idx[IW-1:FAN_IN];
              bus.wr_addr   <= idx[FAN_IN-1:0];
              bus.wr_data   <= bus.s_data[0];
              idx           <= idx + 1'b1;
              sreg          <= bus.s_data >> 1;
              rem           <= RW'(WORD_W - 1);
              word_cnt      <= word_cnt + 1'b1;
              if (final_word) state <= StDrain;
            end
          end else if (rem != '0) begin
            bus.wr_en     <= 1'b1;
            bus.wr_neuron <= idx[IW-1:FAN_IN];
            bus.wr_addr   <= idx[FAN_IN-1:0];
            bus.wr_data   <= sreg[0];
            idx           <= idx + 1'b1;
            sreg          <= sreg >> 1;
            rem           <= rem - 1'b1;
          end else begin
            bus.wr_en <= 1'b0;
            if (state == StDrain) begin
              state <= StIdle;
              done  <= !error;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lut_table_writer.sv
// Scoreboard bench for lut_table_writer: accepted words expand into expected writes, a monitor
// pops one per observed wr_en.
module tb_lut_table_writer;
  localparam int FAN_IN    = 6;
  localparam int N_NEURONS = 64;
  localparam int WORD_W    = 8;
  localparam int ENTRIES   = 2 ** FAN_IN;
  localparam int TOTAL     = N_NEURONS * ENTRIES / WORD_W;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic busy, done, error;

  lut_table_writer_if #(.FAN_IN(FAN_IN), .N_NEURONS(N_NEURONS), .WORD_W(WORD_W)) bus ();

  lut_table_writer #(.FAN_IN(FAN_IN), .N_NEURONS(N_NEURONS), .WORD_W(WORD_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_q[$];
  int m_words  = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int acc0_cyc = -1;
  int prev_n   = -1;
  int prev_a   = -1;
  int prev_cyc = -10;
  bit wrap_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and reference model: entry k of the layer is bit (k % WORD_W) of word k / WORD_W,
  // landing at neuron k / 2**FAN_IN, address k % 2**FAN_IN.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.wr_en) begin
          wr_cnt++;
          if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
          else chk("wr_entry", int'({bus.wr_neuron, bus.wr_addr, bus.wr_data}), exp_q.pop_front());
          if (prev_n == 0 && prev_a == ENTRIES - 1 && int'(bus.wr_neuron) == 1 &&
              int'(bus.wr_addr) == 0 && prev_cyc == cyc - 1) wrap_seen = 1;
          prev_n   = int'(bus.wr_neuron);
          prev_a   = int'(bus.wr_addr);
          prev_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (start && !busy && !abort) m_words = 0;
        if (abort && busy) begin
          exp_q.delete();
        end else if (bus.s_valid && bus.s_ready) begin
          if (bus.s_last == (m_words == TOTAL - 1)) begin
            if (m_words == 0) acc0_cyc = cyc;
            for (int i = 0; i < WORD_W; i++) begin
              int k;
              k = m_words * WORD_W + i;
              exp_q.push_back(((k / ENTRIES) << (FAN_IN + 1)) | ((k % ENTRIES) << 1) |
                              int'(bus.s_data[i]));
            end
            m_words++;
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Sends words until nwords are accepted; s_last on word last_at; abort instead of word abort_at.
  task automatic drive(input int nwords, input int last_at, input int abort_at,
                       input bit rnd_valid, input bit fixed_a5);
    int k     = 0;
    int guard = 0;
    bit pend  = 0;
    while (k < nwords && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      if (k == abort_at) begin
        bus.s_valid = 1'b0;
        abort       = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        break;
      end
      if (!pend) begin
        bus.s_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.s_data  = fixed_a5 ? 8'hA5 : 8'($urandom);
        bus.s_last  = (k == last_at);
        pend        = bus.s_valid;
      end
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) begin
        k++;
        pend = 0;
      end
    end
    if (guard >= 20000) chk("drive_timeout", k, nwords);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  int w0, d0;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", int'(bus.s_ready), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_error", int'(error), 0);
    rst = 1'b0;

    // Reset asserted while bits are still being written
    pulse_start();
    drive(5, -1, -1, 0, 0);
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_wr_en", int'(bus.wr_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wr_en", int'(bus.wr_en), 0);
    chk("midrst_s_ready", int'(bus.s_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_error", int'(error), 0);
    chk("midrst_wr_neuron", int'(bus.wr_neuron), 0);
    chk("midrst_wr_addr", int'(bus.wr_addr), 0);
    chk("midrst_wr_data", int'(bus.wr_data), 0);
    exp_q.delete();
    @(negedge clk) rst = 1'b0;

    // Full load of 8'hA5 back-to-back
    w0 = wr_cnt; d0 = done_cnt; wrap_seen = 0;
    pulse_start();
    drive(TOTAL, TOTAL - 1, -1, 0, 1);
    wait_idle();
    chk("full_wr_count", wr_cnt - w0, TOTAL * WORD_W);
    chk("full_done_count", done_cnt - d0, 1);
    chk("full_done_latency", done_cyc - acc0_cyc, TOTAL * WORD_W + 1);
    chk("full_error", int'(error), 0);
    chk("full_q_empty", exp_q.size(), 0);
    chk("wrap_63_to_0", int'(wrap_seen), 1);
    chk("last_neuron", prev_n, N_NEURONS - 1);
    chk("last_addr", prev_a, ENTRIES - 1);

    // Early s_last on word 10
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    drive(11, 10, -1, 1, 0);
    wait_idle();
    chk("early_error", int'(error), 1);
    chk("early_done", done_cnt - d0, 0);
    chk("early_wr_count", wr_cnt - w0, 10 * WORD_W);
    chk("early_q_empty", exp_q.size(), 0);
    chk("early_busy", int'(busy), 0);

    // Missing s_last, then a clean randomized load
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    drive(TOTAL, -1, -1, 0, 0);
    wait_idle();
    chk("nolast_error", int'(error), 1);
    chk("nolast_done", done_cnt - d0, 0);
    chk("nolast_wr_count", wr_cnt - w0, (TOTAL - 1) * WORD_W);
    pulse_start();
    @(negedge clk);
    chk("start_clears_error", int'(error), 0);
    w0 = wr_cnt; d0 = done_cnt;
    drive(TOTAL, TOTAL - 1, -1, 1, 0);
    wait_idle();
    chk("clean_error", int'(error), 0);
    chk("clean_done", done_cnt - d0, 1);
    chk("clean_wr_count", wr_cnt - w0, TOTAL * WORD_W);
    chk("clean_q_empty", exp_q.size(), 0);

    // Abort right after word 100 is requested (word 99 accepted just before)
    w0 = wr_cnt;
    pulse_start();
    drive(TOTAL, -1, 100, 1, 0);
    @(negedge clk);
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_error", int'(error), 1);
    repeat (10) @(negedge clk);
    chk("abort_wr_count", wr_cnt - w0, 99 * WORD_W + 1);

    // start and abort together in IDLE: stay idle
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", int'(busy), 0);
    chk("start_abort_ready", int'(bus.s_ready), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
